// File: rtl/d_e_md_issue_pkg.sv
// rtl/d_e_md_issue_pkg.sv - mult/div control encodings shared by decoder, D/E issue and the mult/div unit
package d_e_md_issue_pkg;

    localparam logic [3:0] MD_MULT      = 4'b0000;
    localparam logic [3:0] MD_MULTU     = 4'b0001;
    localparam logic [3:0] MD_DIV       = 4'b0010;
    localparam logic [3:0] MD_DIVU      = 4'b0011;
    localparam logic [3:0] MD_MTHI      = 4'b0100;
    localparam logic [3:0] MD_MTLO      = 4'b0101;
    localparam logic [3:0] MD_MFHI      = 4'b0110;
    localparam logic [3:0] MD_MFLO      = 4'b0111;
    localparam logic [3:0] MD_CTRL_NONE = 4'b1111;

    // mult/multu/div/divu: the only codes that occupy the unit for many cycles
    function automatic logic is_long_op(input logic [3:0] ctrl);
        return ctrl[3:2] == 2'b00;
    endfunction

    // Any code 1xxx is treated as "no HI/LO use", not just 1111
    function automatic logic uses_md(input logic [3:0] ctrl);
        return ctrl[3] == 1'b0;
    endfunction

endpackage

// File: rtl/d_e_md_issue_ctl.sv
// rtl/d_e_md_issue_ctl.sv - mult/div start pulse, HI/LO structural stall and stall-cycle counter
module d_e_md_issue_ctl
    import d_e_md_issue_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_d_valid,
    input  logic [3:0]       i_d_md_ctrl,
    input  logic             i_e_valid,
    input  logic [3:0]       i_e_md_ctrl,
    input  logic             i_e_hold,
    input  logic             i_md_busy,
    output logic             o_md_start,
    output logic             o_md_stall,
    output logic [CNT_W-1:0] o_md_stall_cnt
);

    logic             r_issued;
    logic [CNT_W-1:0] r_cnt;
    logic             w_md_start;
    logic             w_md_pending;
    logic             w_md_stall;

    assign w_md_start   = i_e_valid & is_long_op(i_e_md_ctrl) & ~r_issued;
    assign w_md_pending = w_md_start | i_md_busy;
    assign w_md_stall   = i_d_valid & uses_md(i_d_md_ctrl) & w_md_pending;

    // issued remembers a start already sent while E is frozen; any E load or bubble clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issued <= 1'b0;
        end else if (i_e_hold) begin
            if (w_md_start) begin
                r_issued <= 1'b1;
            end
        end else begin
            r_issued <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_md_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_md_start     = w_md_start;
    assign o_md_stall     = w_md_stall;
    assign o_md_stall_cnt = r_cnt;

endmodule

// File: rtl/d_e_md_issue.sv
// rtl/d_e_md_issue.sv - D/E pipeline register with mult/div issue control
module d_e_md_issue
    import d_e_md_issue_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [3:0] MD_NONE = MD_CTRL_NONE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      D_instr,
    input  logic [31:0]      D_pc,
    input  logic [31:0]      D_rs_val,
    input  logic [31:0]      D_rt_val,
    input  logic [3:0]       D_md_ctrl,
    input  logic             D_valid,
    input  logic             hz_stall,
    input  logic             e_hold,
    input  logic             md_busy,
    output logic             stall_D,
    output logic [31:0]      E_instr,
    output logic [31:0]      E_pc,
    output logic [31:0]      E_A,
    output logic [31:0]      E_B,
    output logic [3:0]       E_md_ctrl,
    output logic             E_valid,
    output logic             md_start,
    output logic [CNT_W-1:0] md_stall_cnt
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_md_ctrl;
    logic        r_valid;
    logic        w_md_stall;

    d_e_md_issue_ctl #(
        .CNT_W (CNT_W)
    ) u_ctl (
        .clk            (clk),
        .reset          (reset),
        .i_d_valid      (D_valid),
        .i_d_md_ctrl    (D_md_ctrl),
        .i_e_valid      (r_valid),
        .i_e_md_ctrl    (r_md_ctrl),
        .i_e_hold       (e_hold),
        .i_md_busy      (md_busy),
        .o_md_start     (md_start),
        .o_md_stall     (w_md_stall),
        .o_md_stall_cnt (md_stall_cnt)
    );

    assign stall_D = hz_stall | w_md_stall | e_hold;

    // Hold outranks bubble so a frozen E keeps its instruction even while D is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= '0;
            r_pc      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_md_ctrl <= MD_NONE;
            r_valid   <= 1'b0;
        end else if (e_hold) begin
            r_instr   <= r_instr;
        end else if (hz_stall || w_md_stall) begin
            r_instr   <= '0;
            r_pc      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_md_ctrl <= MD_NONE;
            r_valid   <= 1'b0;
        end else begin
            r_instr   <= D_instr;
            r_pc      <= D_pc;
            r_a       <= D_rs_val;
            r_b       <= D_rt_val;
            r_md_ctrl <= D_valid ? D_md_ctrl : MD_NONE;
            r_valid   <= D_valid;
        end
    end

    assign E_instr   = r_instr;
    assign E_pc      = r_pc;
    assign E_A       = r_a;
    assign E_B       = r_b;
    assign E_md_ctrl = r_md_ctrl;
    assign E_valid   = r_valid;

endmodule

// File: tb/tb_d_e_md_issue.sv
// tb/tb_d_e_md_issue.sv - directed self-checking bench for d_e_md_issue
module tb_d_e_md_issue;

    logic        clk;
    logic        reset;
    logic [31:0] D_instr, D_pc, D_rs_val, D_rt_val;
    logic [3:0]  D_md_ctrl;
    logic        D_valid, hz_stall, e_hold, md_busy;

    logic        stall_D, E_valid, md_start;
    logic [31:0] E_instr, E_pc, E_A, E_B;
    logic [3:0]  E_md_ctrl;
    logic [31:0] md_stall_cnt;

    logic        s_stall_D, s_E_valid, s_md_start;
    logic [31:0] s_E_instr, s_E_pc, s_E_A, s_E_B;
    logic [3:0]  s_E_md_ctrl;
    logic [2:0]  s_md_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    d_e_md_issue dut (
        .clk(clk), .reset(reset), .D_instr(D_instr), .D_pc(D_pc),
        .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .D_md_ctrl(D_md_ctrl),
        .D_valid(D_valid), .hz_stall(hz_stall), .e_hold(e_hold), .md_busy(md_busy),
        .stall_D(stall_D), .E_instr(E_instr), .E_pc(E_pc), .E_A(E_A), .E_B(E_B),
        .E_md_ctrl(E_md_ctrl), .E_valid(E_valid), .md_start(md_start),
        .md_stall_cnt(md_stall_cnt)
    );

    d_e_md_issue #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .D_instr(D_instr), .D_pc(D_pc),
        .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .D_md_ctrl(D_md_ctrl),
        .D_valid(D_valid), .hz_stall(hz_stall), .e_hold(e_hold), .md_busy(md_busy),
        .stall_D(s_stall_D), .E_instr(s_E_instr), .E_pc(s_E_pc), .E_A(s_E_A), .E_B(s_E_B),
        .E_md_ctrl(s_E_md_ctrl), .E_valid(s_E_valid), .md_start(s_md_start),
        .md_stall_cnt(s_md_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] pc, input logic [3:0] ctrl,
                           input logic [31:0] rs, input logic [31:0] rt);
        D_instr   = pc ^ 32'hA5A5_0000;
        D_pc      = pc;
        D_md_ctrl = ctrl;
        D_rs_val  = rs;
        D_rt_val  = rt;
        D_valid   = 1'b1;
        #1;
    endtask

    int stalls, bubbles, enter_cyc, starts;

    initial begin
        reset = 1'b1; hz_stall = 1'b0; e_hold = 1'b0; md_busy = 1'b0;
        drive_d(32'h0000_2000, 4'b0000, 32'd1, 32'd2);

        // reset with a valid mult sitting in D
        tick(); tick();
        expect_eq("rst_E_valid", E_valid, 1'b0);
        expect_eq("rst_E_md_ctrl", E_md_ctrl, 4'hF);
        expect_eq("rst_md_start", md_start, 1'b0);
        expect_eq("rst_cnt", md_stall_cnt, 32'd0);
        expect_eq("rst_E_pc", E_pc, 32'd0);
        expect_eq("rst_stall_D", stall_D, 1'b0);

        // plain load
        reset = 1'b0;
        drive_d(32'h0000_3000, 4'hF, 32'd0, 32'd0);
        expect_eq("plain_stall_D", stall_D, 1'b0);
        tick();
        expect_eq("plain_E_pc", E_pc, 32'h3000);
        expect_eq("plain_E_instr", E_instr, 32'hA5A5_3000);
        expect_eq("plain_E_valid", E_valid, 1'b1);
        expect_eq("plain_md_start", md_start, 1'b0);

        // mult issue
        drive_d(32'h0000_3004, 4'b0000, 32'd3, 32'd5);
        tick();
        expect_eq("mult_E_A", E_A, 32'd3);
        expect_eq("mult_E_B", E_B, 32'd5);
        expect_eq("mult_E_md_ctrl", E_md_ctrl, 4'b0000);
        expect_eq("mult_md_start", md_start, 1'b1);

        // mflo behind it; unit busy for 5 cycles after the start cycle
        drive_d(32'h0000_3008, 4'b0111, 32'd0, 32'd0);
        stalls = 0; bubbles = 0; enter_cyc = -1; starts = 0;
        for (int c = 0; c < 10; c++) begin
            md_busy = (c >= 1 && c <= 5);
            #1;
            if (stall_D) stalls++;
            if (md_start) starts++;
            if (c >= 1 && !E_valid) bubbles++;
            if (enter_cyc < 0 && E_valid && E_md_ctrl == 4'b0111) enter_cyc = c;
            tick();
        end
        expect_eq("mflo_stall_cycles", stalls, 6);
        expect_eq("mflo_bubbles", bubbles, 6);
        expect_eq("mflo_enter_cycle", enter_cyc, 7);
        expect_eq("mult_start_pulses", starts, 1);
        expect_eq("mflo_cnt", md_stall_cnt, 32'd6);

        // div held in E for 4 cycles
        drive_d(32'h0000_4000, 4'b0010, 32'd100, 32'd7);
        tick();
        e_hold = 1'b1;
        drive_d(32'h0000_5000, 4'hF, 32'd0, 32'd0);
        starts = 0; stalls = 0;
        for (int c = 0; c < 4; c++) begin
            if (md_start) starts++;
            if (stall_D) stalls++;
            expect_eq("hold_E_pc", E_pc, 32'h4000);
            expect_eq("hold_E_A", E_A, 32'd100);
            expect_eq("hold_E_md_ctrl", E_md_ctrl, 4'b0010);
            if (c == 0) expect_eq("hold_first_start", md_start, 1'b1);
            tick();
        end
        expect_eq("hold_start_pulses", starts, 1);
        expect_eq("hold_stall_D_cycles", stalls, 4);
        e_hold = 1'b0;
        #1;
        expect_eq("hold_release_stall_D", stall_D, 1'b0);
        tick();
        expect_eq("after_hold_E_pc", E_pc, 32'h5000);
        expect_eq("after_hold_md_start", md_start, 1'b0);
        expect_eq("hold_not_counted", md_stall_cnt, 32'd6);

        // hz_stall alone: bubble, not counted
        hz_stall = 1'b1;
        #1;
        expect_eq("hz_stall_D", stall_D, 1'b1);
        tick();
        expect_eq("hz_bubble_valid", E_valid, 1'b0);
        expect_eq("hz_bubble_ctrl", E_md_ctrl, 4'hF);
        expect_eq("hz_not_counted", md_stall_cnt, 32'd6);
        hz_stall = 1'b0;

        // non-HI/LO op after a long op is not stalled, even while busy
        drive_d(32'h0000_6000, 4'b0001, 32'd9, 32'd9);
        tick();
        expect_eq("multu_start", md_start, 1'b1);
        drive_d(32'h0000_6004, 4'hF, 32'd0, 32'd0);
        expect_eq("plain_after_long", stall_D, 1'b0);
        tick();
        md_busy = 1'b1;
        #1;
        expect_eq("plain_while_busy", stall_D, 1'b0);
        expect_eq("plain_loaded", E_pc, 32'h6004);

        // reset mid-operation with a long op in E
        md_busy = 1'b0;
        drive_d(32'h0000_7000, 4'b0011, 32'd1, 32'd1);
        tick();
        expect_eq("divu_start", md_start, 1'b1);
        reset = 1'b1;
        tick();
        expect_eq("midrst_md_start", md_start, 1'b0);
        expect_eq("midrst_E_valid", E_valid, 1'b0);
        expect_eq("midrst_cnt", md_stall_cnt, 32'd0);
        reset = 1'b0;

        // saturation: 10 md_stall cycles, first 3 also with hz_stall
        drive_d(32'h0000_8000, 4'b0110, 32'd0, 32'd0);
        md_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            hz_stall = (c < 3);
            #1;
            if (c < 3) expect_eq("hz_md_both_stall", stall_D, 1'b1);
            tick();
            if (c < 3) expect_eq("hz_md_bubble", E_valid, 1'b0);
        end
        hz_stall = 1'b0;
        md_busy = 1'b0;
        expect_eq("cnt32_after_10", md_stall_cnt, 32'd10);
        expect_eq("cnt3_saturated", s_md_stall_cnt, 3'd7);
        tick();
        expect_eq("mfhi_enters", E_md_ctrl, 4'b0110);
        expect_eq("cnt3_stays", s_md_stall_cnt, 3'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d_e_md_issue.md
Name: d_e_md_issue

Overview:
- D/E pipeline register for the E stage, combined with issue control for the E-stage multiply/divide unit.
- Captures decoded D-stage fields, inserts bubbles on stall, and produces a single-cycle `start` pulse toward the mult/div unit for each mult/multu/div/divu.
- Generates the HI/LO structural-hazard stall: any D-stage instruction using HI/LO waits while the unit is busy or starting.
- Keeps a saturating count of cycles lost to mult/div stalls.

Parameters:
- CNT_W, 32, width of the mult/div stall-cycle counter.
- MD_NONE, 4'b1111, control code for "no HI/LO use"; it is the bubble value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- D_instr  in  32  D-stage instruction word
- D_pc  in  32  D-stage PC
- D_rs_val  in  32  forwarded rs operand
- D_rt_val  in  32  forwarded rt operand
- D_md_ctrl  in  4  mult/div control code (encodings in Behaviour)
- D_valid  in  1  D holds a real instruction
- hz_stall  in  1  data-hazard stall from the hazard unit
- e_hold  in  1  freeze E (downstream wait)
- md_busy  in  1  busy from the mult/div unit
- stall_D  out  1  freeze F/D registers
- E_instr, E_pc, E_A, E_B  out  32 each  registered E-stage fields (E_A = rs, E_B = rt)
- E_md_ctrl  out  4  registered control code to the mult/div unit
- E_valid  out  1  E holds a real instruction
- md_start  out  1  one-cycle start pulse to the mult/div unit
- md_stall_cnt  out  CNT_W  saturating count of mult/div stall cycles

Behaviour:
- Control encodings:
  - 0000 mult, 0001 multu, 0010 div, 0011 divu: these four are "long ops".
  - 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo.
  - 1111 none.
  - All other codes are treated as none.
- D_uses_md = D_valid and D_md_ctrl in 0000..0111.
- md_pending = md_start | md_busy.
- md_stall = D_uses_md & md_pending. This is combinational.
- stall_D = hz_stall | md_stall | e_hold. This is combinational.
- E register update, in priority order:
  1. reset: all E fields 0, E_md_ctrl = MD_NONE, E_valid = 0.
  2. e_hold: all E fields keep their value.
  3. hz_stall or md_stall: bubble. E fields 0, E_md_ctrl = MD_NONE, E_valid = 0.
  4. otherwise: load all D fields. If D_valid = 0, E_md_ctrl = MD_NONE.
- issued flag (internal):
  - reset clears it.
  - Set on any cycle where md_start = 1 and e_hold = 1.
  - Cleared whenever E loads or takes a bubble.
- md_start = E_valid & (E_md_ctrl in 0000..0011) & ~issued. It is combinational from registers.
  - Exactly one pulse per long op, even if E is held for many cycles.
  - mthi/mtlo never pulse md_start; the unit acts on E_md_ctrl directly.
- Latency: a D instruction appears on E outputs 1 cycle after a non-stalled edge. md_start is high in the first cycle the long op is in E.
- md_stall_cnt:
  - reset sets it to 0.
  - Increments by 1 each cycle md_stall = 1, saturating at all-ones.
  - Cycles stalled only by hz_stall or e_hold are not counted.
- Back-to-back long ops: the second one stalls in D while the first is in E (md_start = 1), then for every md_busy cycle. It enters E on the edge after md_busy falls.
- A non-HI/LO instruction following a long op is never stalled by md_stall.
- Simultaneous hz_stall and md_stall: one bubble per cycle; the counter still increments.
- Reset mid-operation:
  - E becomes a bubble and issued clears.
  - md_start is 0 in the first cycle after reset.
  - md_busy clearing is owned by the mult/div unit.
- All outputs are defined at reset: E_* = 0, E_md_ctrl = MD_NONE, E_valid = 0, md_start = 0, md_stall_cnt = 0. stall_D follows its inputs.

Decomposition:
- Shared package holds the md control encodings (MULT..MFLO, MD_NONE) and an is_long_op/uses_md helper, shared with the mult/div unit and the decoder.
- One natural sub-module: md_issue_ctl, containing the issued flag, md_start, md_stall and the counter. The pipeline registers stay in the top.

Test Plan:
1. Reset: assert reset 2 cycles with D_valid = 1 -> E_valid = 0, E_md_ctrl = 1111, md_start = 0, md_stall_cnt = 0.
2. Plain load: D_pc = 0x3000, D_md_ctrl = 1111, no stalls -> next cycle E_pc = 0x3000, E_valid = 1, md_start = 0, stall_D = 0.
3. mult issue: D_md_ctrl = 0000, D_rs_val = 3, D_rt_val = 5 -> next cycle E_A = 3, E_B = 5, md_start = 1 for exactly 1 cycle.
4. mult then mflo: drive md_busy high 5 cycles after the start -> stall_D = 1 for 6 cycles, 6 bubbles in E, mflo enters E the edge after md_busy falls, md_stall_cnt = 6.
5. e_hold with div in E for 4 cycles -> md_start high only in the first cycle, E fields unchanged, stall_D = 1 throughout.
6. Saturation: CNT_W = 3, hold md_stall high for 10 cycles -> md_stall_cnt stops at 7.
